// File: rtl/adc_pkg.sv
// Shared definitions for the ADC acquisition path: FSM encoding, default
// timing for a 50 MHz system clock, and the sample width that the display
// stage also consumes.
package adc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CONV  = 2'd3
    } adc_state_e;

    // 50 MHz -> 1 MHz ad_clk, 2 us chip-select setup, 20 us conversion.
    localparam int ADC_CLK_DIV   = 25;
    localparam int ADC_SETUP_CYC = 100;
    localparam int ADC_CONV_CYC  = 1000;
    localparam int ADC_DATA_W    = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tlc549_serial_reader_tick_divider.sv
// Modulo-MOD counter with synchronous clear. tick_o is high for the single
// cycle in which the counter sits at its terminal count (and is not being
// cleared), so a consumer acting on tick_o sees one event every MOD cycles.
module tick_divider #(
    parameter int MOD = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (MOD > 1) ? $clog2(MOD) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise wrap at MOD-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == W'(MOD - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == W'(MOD - 1));

endmodule

// File: rtl/tlc549_serial_reader.sv
// Serial reader for a TLC549-class 8-bit ADC. Drives ad_cs / ad_clk,
// shifts ad_data in MSB-first and presents each result as a parallel sample.
//
// Output handshake: sample_valid is a pure one-cycle strobe with no ready
// back-pressure; the consumer must take sample on the strobe cycle (sample
// then holds until the next strobe anyway).
module tlc549_serial_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV   = ADC_CLK_DIV,
    parameter int SETUP_CYC = ADC_SETUP_CYC,
    parameter int CONV_CYC  = ADC_CONV_CYC,
    parameter int DATA_W    = ADC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ad_data,
    output logic              ad_cs,
    output logic              ad_clk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output adc_state_e        state_dbg
);

    localparam int CNT_W = $clog2(max2(SETUP_CYC, CONV_CYC) + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    adc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              ad_clk_q, ad_clk_d;
    logic              ad_cs_q, ad_cs_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [1:0]        sync_q;
    logic              data_s;
    logic              half_tick;

    // ad_data is asynchronous to clk; two flops before it is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], ad_data};
        end
    end

    assign data_s = sync_q[1];

    // ad_clk half-period timer; held cleared outside SHIFT so the first
    // rise lands exactly CLK_DIV cycles after SETUP ends.
    tick_divider #(
        .MOD (CLK_DIV)
    ) u_half_div (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != ST_SHIFT),
        .tick_o (half_tick)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sample_d  = sample_q;
        ad_clk_d  = ad_clk_q;
        valid_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d   = ST_SETUP;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (half_tick) begin
                    if (!ad_clk_q) begin
                        // Rising ad_clk: the bit the ADC put out on the last
                        // fall has had CLK_DIV cycles to pass the synchronizer.
                        ad_clk_d  = 1'b1;
                        shift_d   = {shift_q[DATA_W-2:0], data_s};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        ad_clk_d = 1'b0;
                        if (bit_cnt_q == BIT_W'(DATA_W)) begin
                            state_d  = ST_CONV;
                            sample_d = shift_q;
                            valid_d  = 1'b1;
                            cnt_d    = '0;
                        end
                    end
                end
            end
            ST_CONV: begin
                if (cnt_q == CNT_W'(CONV_CYC - 1)) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = en ? ST_SETUP : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Chip select follows the state being entered, so it moves on the
        // same edge as the transition.
        ad_cs_d = (state_d == ST_IDLE) || (state_d == ST_CONV);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs; reset aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            sample_q  <= '0;
            ad_clk_q  <= 1'b0;
            ad_cs_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            sample_q  <= sample_d;
            ad_clk_q  <= ad_clk_d;
            ad_cs_q   <= ad_cs_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign ad_cs        = ad_cs_q;
    assign ad_clk       = ad_clk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign state_dbg    = state_q;

endmodule
